// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame-size encodings and the CRC compare mask helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package spi_pkg;

  localparam logic [1:0] DF_8  = 2'b00;
  localparam logic [1:0] DF_16 = 2'b01;
  localparam logic [1:0] DF_32 = 2'b10;

  // Bits of a right-aligned frame that take part in the CRC compare.
  function automatic logic [31:0] df_mask(input logic [1:0] df);
    logic [31:0] m;
    case (df)
      DF_8:    m = 32'h0000_00FF;
      DF_16:   m = 32'h0000_FFFF;
      DF_32:   m = 32'hFFFF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Show-ahead FIFO for received frames; flush empties it without touching stored data.
// Latency: push visible on rd_data/lvl the edge after it is accepted.
// Backpressure: push at full is dropped unless a pop happens the same cycle; pop at empty ignored.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   lvl,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic          do_push, do_pop;

  assign empty   = (lvl_q == '0);
  assign full    = (lvl_q == LVL_FULL);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign do_push = push & (~full | do_pop);

  assign lvl   = lvl_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointer/level: flush dominates, otherwise advance on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      lvl_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   lvl_d = lvl_q + 1'b1;
        2'b01:   lvl_d = lvl_q - 1'b1;
        default: lvl_d = lvl_q;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
    end
  end

  // Storage array; contents need no reset because the level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/spi_rx_buf.sv
// RX buffer after the SPI shifter: frame capture into a FIFO, CRC check, RXNE/level/OVR/CRC-error flags.
// Latency: frame whose rx_busy falls after edge N is stored/checked at edge N+1.
// Backpressure: none upstream; frames arriving at a full FIFO with no pop are dropped and set ovr.
module spi_rx_buf
  import spi_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_rx,
  input  logic          spi_rx_rst,
  input  logic          rx_en,
  input  logic [1:0]    df,
  input  logic          crc_en,
  input  logic          rx_busy,
  input  logic [DW-1:0] spi_rx_data,
  input  logic          rx_crc_en,
  input  logic [31:0]   crc_calc,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rxne,
  output logic [AW:0]   fifo_lvl,
  output logic          ovr,
  input  logic          ovr_clr,
  output logic          crc_err,
  input  logic          crc_err_clr,
  output logic          crc_done
);

  logic        busy_q;
  logic        rxcrc_q;
  logic [31:0] crc_snap_q, crc_snap_d;
  logic        ovr_q, ovr_d;
  logic        crc_err_q, crc_err_d;
  logic        crc_done_q, crc_done_d;

  logic        frame_done, crc_frame, data_frame;
  logic        pop_ok, fifo_full, fifo_empty;
  logic        ovr_set, crc_mismatch;
  logic [31:0] rx_data32;

  assign frame_done = busy_q & ~rx_busy & rx_en;
  assign crc_frame  = frame_done & crc_en & rx_crc_en;
  assign data_frame = frame_done & ~(crc_en & rx_crc_en);

  assign pop_ok  = rd_en & rxne;
  assign ovr_set = data_frame & fifo_full & ~pop_ok;

  assign rx_data32    = 32'(spi_rx_data);
  assign crc_mismatch = |((rx_data32 ^ crc_snap_q) & df_mask(df));

  assign rxne     = (fifo_lvl != '0);
  assign ovr      = ovr_q;
  assign crc_err  = crc_err_q;
  assign crc_done = crc_done_q;

  spi_rx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk_rx),
    .rst   (spi_rx_rst),
    .flush (~rx_en),
    .push  (data_frame),
    .pop   (rd_en),
    .wdata (spi_rx_data),
    .rdata (rd_data),
    .lvl   (fifo_lvl),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // CRC snapshot on rx_crc_en rise; sticky flags where a set beats a same-cycle clear.
  always_comb begin
    crc_snap_d = crc_snap_q;
    ovr_d      = ovr_q;
    crc_err_d  = crc_err_q;
    crc_done_d = crc_frame;
    if (rx_crc_en && !rxcrc_q) crc_snap_d = crc_calc;
    if (ovr_set)      ovr_d = 1'b1;
    else if (ovr_clr) ovr_d = 1'b0;
    if (crc_frame && crc_mismatch) crc_err_d = 1'b1;
    else if (crc_err_clr)          crc_err_d = 1'b0;
  end

  // Edge-detect history, snapshot and flag registers.
  always_ff @(posedge clk_rx) begin
    if (spi_rx_rst) begin
      busy_q     <= 1'b0;
      rxcrc_q    <= 1'b0;
      crc_snap_q <= '0;
      ovr_q      <= 1'b0;
      crc_err_q  <= 1'b0;
      crc_done_q <= 1'b0;
    end else begin
      busy_q     <= rx_busy;
      rxcrc_q    <= rx_crc_en;
      crc_snap_q <= crc_snap_d;
      ovr_q      <= ovr_d;
      crc_err_q  <= crc_err_d;
      crc_done_q <= crc_done_d;
    end
  end

endmodule
